// File: rtl/register_write_buffer_pkg.sv
// Shared constants and the slot record for the register write buffer.
package register_write_buffer_pkg;

  localparam int unsigned SLOT_DEPTH = 3;
  localparam int unsigned REG_IDX_W  = 5;
  localparam int unsigned DATA_W     = 32;

  typedef struct packed {
    logic                 valid;
    logic [REG_IDX_W-1:0] addr;
    logic                 is_float;
    logic [DATA_W-1:0]    data;
  } slot_t;

  // Integer register r0 is hardwired to zero, so writes to it are dropped.
  function automatic logic is_accepted(input logic enable, input logic is_float,
                                       input logic [REG_IDX_W-1:0] addr);
    return enable && !(!is_float && (addr == '0));
  endfunction

endpackage

// File: rtl/register_write_buffer_slot.sv
// One write-buffer slot: load, hold or clear. Invalid entries are stored as all-zero.
module register_write_slot
  import register_write_buffer_pkg::*;
(
  input  logic  clk,
  input  logic  reset,
  input  logic  load,
  input  slot_t d,
  output slot_t q
);

  // Slot register; clears on reset, zeroes payload of any invalid entry loaded.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q <= '0;
    end else if (load) begin
      q <= d.valid ? d : '0;
    end
  end

endmodule

// File: rtl/register_write_buffer.sv
// Three-slot register write buffer between execute and the register files.
// Slot 2 is newest, slot 0 oldest; slot 0 retires through the rf_* strobes.
// Optional feature: define REGISTER_WRITE_BUFFER_DRAIN_EN to keep shifting and
// retiring during stall (a bubble is loaded into slot 2).
module register_write_buffer
  import register_write_buffer_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_enable,
  input  logic [REG_IDX_W-1:0] in_addr,
  input  logic                 in_float,
  input  logic [DATA_W-1:0]    in_data,
  input  logic                 stall,
  output logic                 write_enable_0,
  output logic [REG_IDX_W-1:0] write_addr_0,
  output logic                 write_float_0,
  output logic [DATA_W-1:0]    write_data_0,
  output logic                 write_enable_1,
  output logic [REG_IDX_W-1:0] write_addr_1,
  output logic                 write_float_1,
  output logic [DATA_W-1:0]    write_data_1,
  output logic                 write_enable_2,
  output logic [REG_IDX_W-1:0] write_addr_2,
  output logic                 write_float_2,
  output logic [DATA_W-1:0]    write_data_2,
  output logic                 rf_we_int,
  output logic                 rf_we_float,
  output logic [REG_IDX_W-1:0] rf_addr,
  output logic [DATA_W-1:0]    rf_data,
  output logic [1:0]           pending_count
);

  slot_t      slot_q [SLOT_DEPTH];
  slot_t      slot_d [SLOT_DEPTH];
  slot_t      new_entry;
  logic       shift_en;
  logic       strobe_gate;
  logic [1:0] pending_q;
  logic [1:0] pending_d;

  // Shift/strobe gating: stall freezes the buffer unless draining is compiled in.
  always_comb begin
    shift_en    = 1'b0;
    strobe_gate = 1'b0;
`ifdef REGISTER_WRITE_BUFFER_DRAIN_EN
    shift_en    = 1'b1;
    strobe_gate = 1'b1;
`else
    shift_en    = !stall;
    strobe_gate = !stall;
`endif
  end

  // Build the incoming entry and the shifted slot contents.
  always_comb begin
    new_entry = '0;
    if (!stall && is_accepted(in_enable, in_float, in_addr)) begin
      new_entry.valid    = 1'b1;
      new_entry.addr     = in_addr;
      new_entry.is_float = in_float;
      new_entry.data     = in_data;
    end
    slot_d[2] = new_entry;
    slot_d[1] = slot_q[2];
    slot_d[0] = slot_q[1];
  end

  register_write_slot u_slot_0 (.clk(clk), .reset(reset), .load(shift_en), .d(slot_d[0]), .q(slot_q[0]));
  register_write_slot u_slot_1 (.clk(clk), .reset(reset), .load(shift_en), .d(slot_d[1]), .q(slot_q[1]));
  register_write_slot u_slot_2 (.clk(clk), .reset(reset), .load(shift_en), .d(slot_d[2]), .q(slot_q[2]));

  // Up/down occupancy: +1 for an accepted entry, -1 for a retiring slot 0.
  always_comb begin
    pending_d = pending_q;
    if (shift_en) begin
      if (new_entry.valid && !slot_q[0].valid && pending_q != 2'd3) begin
        pending_d = pending_q + 2'd1;
      end else if (!new_entry.valid && slot_q[0].valid && pending_q != 2'd0) begin
        pending_d = pending_q - 2'd1;
      end
    end
  end

  // Occupancy register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pending_q <= '0;
    end else begin
      pending_q <= pending_d;
    end
  end

  assign pending_count  = pending_q;

  assign rf_we_int      = slot_q[0].valid && !slot_q[0].is_float && strobe_gate;
  assign rf_we_float    = slot_q[0].valid &&  slot_q[0].is_float && strobe_gate;
  assign rf_addr        = slot_q[0].addr;
  assign rf_data        = slot_q[0].data;

  assign write_enable_0 = slot_q[0].valid;
  assign write_addr_0   = slot_q[0].addr;
  assign write_float_0  = slot_q[0].is_float;
  assign write_data_0   = slot_q[0].data;
  assign write_enable_1 = slot_q[1].valid;
  assign write_addr_1   = slot_q[1].addr;
  assign write_float_1  = slot_q[1].is_float;
  assign write_data_1   = slot_q[1].data;
  assign write_enable_2 = slot_q[2].valid;
  assign write_addr_2   = slot_q[2].addr;
  assign write_float_2  = slot_q[2].is_float;
  assign write_data_2   = slot_q[2].data;

endmodule

// File: tb/tb_register_write_buffer.sv
// Directed self-checking bench for register_write_buffer.
// Stall expectations follow REGISTER_WRITE_BUFFER_DRAIN_EN when defined.
module tb_register_write_buffer;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_enable;
  logic [4:0]  in_addr;
  logic        in_float;
  logic [31:0] in_data;
  logic        stall;
  logic        write_enable_0, write_enable_1, write_enable_2;
  logic [4:0]  write_addr_0, write_addr_1, write_addr_2;
  logic        write_float_0, write_float_1, write_float_2;
  logic [31:0] write_data_0, write_data_1, write_data_2;
  logic        rf_we_int, rf_we_float;
  logic [4:0]  rf_addr;
  logic [31:0] rf_data;
  logic [1:0]  pending_count;

  int total = 0;
  int bad   = 0;

  register_write_buffer dut (
    .clk(clk), .reset(reset),
    .in_enable(in_enable), .in_addr(in_addr), .in_float(in_float), .in_data(in_data),
    .stall(stall),
    .write_enable_0(write_enable_0), .write_addr_0(write_addr_0),
    .write_float_0(write_float_0), .write_data_0(write_data_0),
    .write_enable_1(write_enable_1), .write_addr_1(write_addr_1),
    .write_float_1(write_float_1), .write_data_1(write_data_1),
    .write_enable_2(write_enable_2), .write_addr_2(write_addr_2),
    .write_float_2(write_float_2), .write_data_2(write_data_2),
    .rf_we_int(rf_we_int), .rf_we_float(rf_we_float),
    .rf_addr(rf_addr), .rf_data(rf_data),
    .pending_count(pending_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic en, input logic [4:0] addr, input logic flt,
                       input logic [31:0] data);
    in_enable = en;
    in_addr   = addr;
    in_float  = flt;
    in_data   = data;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    stall = 1'b0;
    drive(1'b0, 5'd0, 1'b0, 32'h0);
    #1;
    check("rst_we2", write_enable_2, 0);
    check("rst_pend", pending_count, 0);
    check("rst_rfwe", rf_we_int, 0);
    tick();
    tick();
    reset = 1'b0;

    // int r5 = 0x1234
    drive(1'b1, 5'd5, 1'b0, 32'h1234);
    tick();
    drive(1'b0, 5'd0, 1'b0, 32'h0);
    check("r5_we2", write_enable_2, 1);
    check("r5_addr2", write_addr_2, 5);
    check("r5_data2", write_data_2, 32'h1234);
    check("r5_pend1", pending_count, 1);
    check("r5_rfwe_e1", rf_we_int, 0);
    tick();
    check("r5_we1", write_enable_1, 1);
    check("r5_addr2_zero", write_addr_2, 0);
    check("r5_pend2", pending_count, 1);
    tick();
    check("r5_rfwe", rf_we_int, 1);
    check("r5_rfwf", rf_we_float, 0);
    check("r5_rfaddr", rf_addr, 5);
    check("r5_rfdata", rf_data, 32'h1234);
    check("r5_pend3", pending_count, 1);
    tick();
    check("r5_pend4", pending_count, 0);
    check("r5_rfwe_off", rf_we_int, 0);
    check("r5_rfaddr_zero", rf_addr, 0);

    // int r0 discarded, float f0 accepted
    drive(1'b1, 5'd0, 1'b0, 32'hFFFF);
    tick();
    check("r0_we2", write_enable_2, 0);
    check("r0_data2", write_data_2, 0);
    check("r0_pend", pending_count, 0);
    drive(1'b1, 5'd0, 1'b1, 32'h77);
    tick();
    drive(1'b0, 5'd0, 1'b0, 32'h0);
    check("f0_we2", write_enable_2, 1);
    check("f0_flt2", write_float_2, 1);
    check("f0_pend", pending_count, 1);
    tick();
    check("r0_rfwe_none", rf_we_int, 0);
    tick();
    check("f0_rfwf", rf_we_float, 1);
    check("f0_rfdata", rf_data, 32'h77);
    tick();
    check("f0_pend0", pending_count, 0);

    // f3 = 0xA then int r3 = 0xB back-to-back
    drive(1'b1, 5'd3, 1'b1, 32'hA);
    tick();
    drive(1'b1, 5'd3, 1'b0, 32'hB);
    tick();
    drive(1'b0, 5'd0, 1'b0, 32'h0);
    check("dup_we1", write_enable_1, 1);
    check("dup_flt1", write_float_1, 1);
    check("dup_data1", write_data_1, 32'hA);
    check("dup_we2", write_enable_2, 1);
    check("dup_flt2", write_float_2, 0);
    check("dup_pend", pending_count, 2);
    tick();
    check("dup_rfwf", rf_we_float, 1);
    check("dup_rfwi0", rf_we_int, 0);
    check("dup_rfaddr", rf_addr, 3);
    check("dup_rfdataA", rf_data, 32'hA);
    tick();
    check("dup_rfwi", rf_we_int, 1);
    check("dup_rfwf0", rf_we_float, 0);
    check("dup_rfdataB", rf_data, 32'hB);
    check("dup_pend1", pending_count, 1);
    tick();
    check("dup_pend0", pending_count, 0);

    // fill three entries, then stall four cycles with an input offered
    drive(1'b1, 5'd1, 1'b0, 32'h11);
    tick();
    drive(1'b1, 5'd2, 1'b0, 32'h22);
    tick();
    drive(1'b1, 5'd4, 1'b0, 32'h44);
    tick();
    check("fill_pend", pending_count, 3);
    check("fill_rfwe", rf_we_int, 1);
    drive(1'b1, 5'd7, 1'b0, 32'h77);
    stall = 1'b1;
    #1;
`ifdef REGISTER_WRITE_BUFFER_DRAIN_EN
    check("stall_rfwe", rf_we_int, 1);
    for (int unsigned i = 0; i < 4; i++) begin
      tick();
      check("drain_pend", pending_count, (i < 3) ? 2 - i : 0);
      check("drain_we2", write_enable_2, 0);
    end
    check("drain_rfwe", rf_we_int, 0);
`else
    check("stall_rfwe", rf_we_int, 0);
    for (int unsigned i = 0; i < 4; i++) begin
      tick();
      check("stall_pend", pending_count, 3);
      check("stall_data0", write_data_0, 32'h11);
      check("stall_data2", write_data_2, 32'h44);
      check("stall_rfwe_hold", rf_we_int, 0);
    end
`endif

    // asynchronous reset mid-stall
    #2;
    reset = 1'b1;
    #1;
    check("arst_we0", write_enable_0, 0);
    check("arst_we1", write_enable_1, 0);
    check("arst_we2", write_enable_2, 0);
    check("arst_pend", pending_count, 0);
    check("arst_rfwe", rf_we_int, 0);
    check("arst_rfwf", rf_we_float, 0);
    reset = 1'b0;
    stall = 1'b0;

    // first edge after reset accepts; duplicate r6 entries retire in order
    drive(1'b1, 5'd9, 1'b0, 32'h99);
    tick();
    check("post_we2", write_enable_2, 1);
    check("post_pend", pending_count, 1);
    drive(1'b1, 5'd6, 1'b0, 32'h1);
    tick();
    drive(1'b1, 5'd6, 1'b0, 32'h2);
    tick();
    drive(1'b0, 5'd0, 1'b0, 32'h0);
    check("same_pend", pending_count, 3);
    check("same_rfdata9", rf_data, 32'h99);
    tick();
    check("same_rfdata1", rf_data, 32'h1);
    check("same_pend2", pending_count, 2);
    tick();
    check("same_rfdata2", rf_data, 32'h2);
    check("same_rfaddr", rf_addr, 6);
    tick();
    check("same_pend0", pending_count, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/register_write_buffer.md
REGISTER_WRITE_BUFFER -- requirements
Module: register_write_buffer

Interface
REQ-001 SHALL have port: clk  input  1  sole clock; all state on rising edge.
REQ-002 SHALL have port: reset  input  1  asynchronous, active-high reset.
REQ-003 SHALL have port: in_enable  input  1  writeback request from execute stage.
REQ-004 SHALL have port: in_addr  input  5  destination register index.
REQ-005 SHALL have port: in_float  input  1  1 = float register file, 0 = integer.
REQ-006 SHALL have port: in_data  input  32  writeback value.
REQ-007 SHALL have port: stall  input  1  pipeline hold.
REQ-008 SHALL have ports: write_enable_N / write_addr_N / write_float_N / write_data_N, N=0..2  output  1/5/1/32  slot N contents; slot 2 newest, slot 0 oldest; feeds the forwarding lookup.
REQ-009 SHALL have ports: rf_we_int, rf_we_float  output  1 each  register-file write strobes.
REQ-010 SHALL have ports: rf_addr  output  5 and rf_data  output  32  register-file write address and data.
REQ-011 SHALL have port: pending_count  output  2  number of valid slots, 0..3.

Function
REQ-012 SHALL hold three slots, each {valid, addr, float, data}; write_enable_N equals slot N valid.
REQ-013 SHALL, on a rising edge with stall=0, shift slot2->slot1->slot0 and load slot 2 from the inputs.
REQ-014 SHALL load slot 2 valid = in_enable AND NOT (in_float=0 AND in_addr=0); integer r0 writes are discarded.
REQ-015 SHALL, on a rising edge with stall=0, retire the pre-shift slot 0 through the rf_* outputs if it is valid.
REQ-016 SHALL drive rf_* combinationally from slot 0: rf_we_int = valid AND NOT float AND NOT stall; rf_we_float = valid AND float AND NOT stall; rf_addr and rf_data = slot 0 fields.
REQ-017 SHALL, with stall=1 and no drain feature, hold all slots unchanged, ignore the inputs and deassert both rf_we strobes.
REQ-018 SHALL NOT merge or cancel entries with equal addr/float; duplicates coexist and retire in age order.
REQ-019 SHALL register pending_count as a saturating up/down count kept equal to the number of valid slots at every edge.
REQ-020 SHALL present invalid slots with addr, float and data = 0.
REQ-021 SHALL produce a new entry that is visible on slot 2 one cycle after acceptance and retires on the rf_* outputs three unstalled cycles after acceptance.

Reset
REQ-022 SHALL, while reset=1, clear all slot fields, force pending_count=0 and force rf_we_int=rf_we_float=0, asynchronously and including mid-stall.
REQ-023 SHALL, on the first edge after reset deasserts, accept an entry normally.

Configuration
REQ-024 SHALL compile stall draining only when REGISTER_WRITE_BUFFER_DRAIN_EN is defined.
REQ-025 SHALL, with REGISTER_WRITE_BUFFER_DRAIN_EN defined and stall=1, still shift and retire slot 0 on each edge, load a bubble (valid=0) into slot 2 and ignore the inputs.
REQ-026 SHALL, with REGISTER_WRITE_BUFFER_DRAIN_EN defined, drive the rf_we strobes ignoring stall.
REQ-027 SHALL behave exactly per REQ-017 without REGISTER_WRITE_BUFFER_DRAIN_EN.

Structure
REQ-028 SHALL place the slot depth constant (3), the register index width (5), the data width (32) and the slot record typedef in a shared package.
REQ-029 SHALL implement one slot as sub-module register_write_slot (load/hold/clear); the top SHALL instantiate it three times.

Verification
REQ-030 SHALL cover: write r5=0x1234 int, stall=0 -> write_enable_2=1 next cycle; rf_we_int=1, rf_addr=5, rf_data=0x1234 on the third edge after acceptance; pending_count 1,1,1 then 0 once no further input.
REQ-031 SHALL cover: write int r0=0xFFFF -> no slot becomes valid; pending_count stays 0; no rf strobe.
REQ-032 SHALL cover: f3=0xA then int r3=0xB on back-to-back cycles -> both valid with write_float_1=1, write_float_2=0; retire order rf_we_float then rf_we_int.
REQ-033 SHALL cover: fill 3 entries, stall=1 for 4 cycles -> no drain: slots frozen, pending_count=3, no strobes; drain: one retire per cycle, pending_count 2,1,0,0.
REQ-034 SHALL cover: reset asserted mid-stall with 3 valid entries -> all write_enable_N=0, pending_count=0 and rf_we strobes 0 immediately, without waiting for a clock edge.
